router_sync: RTL and testbench
==============================

// Module: router_sync
// PURPOSE
//  Synchronizer/control glue of the 1x3 packet router, between the input FSM and the three output FIFOs.
//  Latches the destination address of each packet and steers the FSM write strobe to one FIFO.
//  Reports that FIFO's full status back to the FSM and drives per-port valid outputs from FIFO empty flags.
//  Times out unread output ports and issues a soft reset to the stalled FIFO.
// PARAMETERS
//  TIMEOUT_CYCLES  30  consecutive valid-but-unread cycles before soft_reset_x pulses
//  CNT_W           5   width of each timeout counter (must hold TIMEOUT_CYCLES-1)
// PORTS
//  clock          in   1  single clock; all state updates on rising edge
//  resetn         in   1  asynchronous, active-low reset
//  data_in        in   2  destination address field of the header byte (00/01/10 valid, 11 invalid)
//  detect_add     in   1  FSM strobe: header present, capture data_in
//  full_0..2      in   1  FIFO 0/1/2 full flags
//  empty_0..2     in   1  FIFO 0/1/2 empty flags
//  write_enb_reg  in   1  FSM write request for the current packet byte
//  read_enb_0..2  in   1  downstream read enables of output ports 0/1/2
//  fifo_full      out  1  full flag of the currently addressed FIFO
//  write_enb      out  3  one-hot FIFO write enables, bit n -> FIFO n
//  vld_out_0..2   out  1  output port n has data (FIFO n not empty)
//  soft_reset_0..2 out 1  one-cycle timeout reset to FIFO n
// BEHAVIOUR
//  Reset (resetn=0, asynchronous): addr register = 2'b00; all timeout counters = 0; all soft_reset_x = 0.
//  Address register:
//   - On a rising clock edge with detect_add=1, addr <= data_in; otherwise holds.
//   - Holds across packets until the next detect_add.
//  write_enb (combinational):
//   - write_enb_reg=0 -> 3'b000.
//   - Otherwise addr 00->001, 01->010, 10->100, 11->000.
//   - Never more than one bit set.
//  fifo_full (combinational): addr 00->full_0, 01->full_1, 10->full_2, 11->0. Independent of write_enb_reg.
//  vld_out_n = ~empty_n (combinational, zero latency, not affected by reset).
//  Timeout, per port n (three identical, independent channels), at each rising edge:
//   - vld_out_n=1 and read_enb_n=0:
//     - cnt_n==TIMEOUT_CYCLES-1 -> soft_reset_n<=1 and cnt_n<=0.
//     - else soft_reset_n<=0 and cnt_n<=cnt_n+1.
//   - Otherwise (not valid, or being read) -> cnt_n<=0 and soft_reset_n<=0.
//   - soft_reset_n is registered. It rises on the 30th consecutive qualifying edge and stays high exactly one cycle.
//   - If the port stays valid and unread, it pulses again every 30 cycles.
//   - A single cycle with read_enb_n=1 or empty_n=1 restarts the count from zero.
//  Simultaneous events:
//   - detect_add together with write_enb_reg: write_enb uses the old addr until the edge.
//   - Channels never interact; several soft_reset_x may pulse in the same cycle.
//  Reset mid-count: counters and pulses cleared immediately; counting restarts from 0 after release.
// TESTING
//  1. Reset, all empty=1, inputs 0 -> write_enb=000, fifo_full=0, vld_out=000, soft_reset=000.
//  2. data_in=01, detect_add=1, write_enb_reg=1, one edge -> write_enb=010. Set full_1=1 -> fifo_full=1; full_0/full_2 ignored.
//  3. Repeat for addr 00 and 10 -> write_enb 001/100, fifo_full tracks full_0/full_2. Addr 11 -> write_enb=000, fifo_full=0.
//  4. empty_1=0, read_enb_1=0, empty_0=empty_2=1 -> vld_out_1=1.
//     soft_reset_1 high for one cycle after 30 edges, again after 60; soft_reset_0/2 stay 0.
//  5. read_enb_1=1 at cycle 20 of a count -> no pulse. Count restarts after read_enb_1 drops. read_enb_0/2=1 with empty -> no effect.
//  6. Assert resetn=0 at count 25 -> counter cleared. 30 further idle cycles needed for soft_reset_1.

Source files
------------

// File: rtl/router_sync_if.sv
// Signal bundle between the router input FSM / output FIFOs and the router_sync glue.
// The master side drives the FSM and FIFO status; the slave side is router_sync.
interface router_sync_if;
  logic [1:0] data_in;
  logic       detect_add;
  logic       full_0, full_1, full_2;
  logic       empty_0, empty_1, empty_2;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       fifo_full;
  logic [2:0] write_enb;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  // There is no handshake here: every signal is a level, sampled on the rising
  // clock edge or consumed combinationally, and nothing waits on a ready.
  modport master (
    output data_in, detect_add, full_0, full_1, full_2, empty_0, empty_1, empty_2,
           write_enb_reg, read_enb_0, read_enb_1, read_enb_2,
    input  fifo_full, write_enb, vld_out_0, vld_out_1, vld_out_2,
           soft_reset_0, soft_reset_1, soft_reset_2
  );

  modport slave (
    input  data_in, detect_add, full_0, full_1, full_2, empty_0, empty_1, empty_2,
           write_enb_reg, read_enb_0, read_enb_1, read_enb_2,
    output fifo_full, write_enb, vld_out_0, vld_out_1, vld_out_2,
           soft_reset_0, soft_reset_1, soft_reset_2
  );
endinterface

// File: rtl/router_sync.sv
// 1x3 router glue: latches the packet destination, steers FIFO writes, reports the
// addressed FIFO's full flag, and soft-resets output ports left unread too long.
module router_sync #(
  parameter int TIMEOUT_CYCLES = 30,
  parameter int CNT_W          = 5
) (
  input logic          clock,
  input logic          resetn,
  router_sync_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            addr_q, addr_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            soft_reset_q, soft_reset_d;
  logic [2:0]            vld, rd;
  logic [2:0]            write_enb;
  logic                  fifo_full;

  assign vld = ~{bus.empty_2, bus.empty_1, bus.empty_0};
  assign rd  = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};

  always_comb begin
    addr_d = addr_q;
    if (bus.detect_add) addr_d = bus.data_in;
  end

  // Steering uses the registered address, so a header arriving together with a
  // write strobe still routes that byte to the previous destination.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_q)
      2'b00:   begin write_enb = 3'b001; fifo_full = bus.full_0; end
      2'b01:   begin write_enb = 3'b010; fifo_full = bus.full_1; end
      2'b10:   begin write_enb = 3'b100; fifo_full = bus.full_2; end
      default: begin write_enb = 3'b000; fifo_full = 1'b0;       end
    endcase
    if (!bus.write_enb_reg) write_enb = 3'b000;
  end

  // Per-port stall timer: counts consecutive valid-but-unread edges and wraps
  // to zero on the edge that raises the one-cycle soft reset.
  always_comb begin
    cnt_d        = cnt_q;
    soft_reset_d = 3'b000;
    for (int n = 0; n < 3; n++) begin
      if (vld[n] && !rd[n]) begin
        if (cnt_q[n] == CNT_MAX) begin
          soft_reset_d[n] = 1'b1;
          cnt_d[n]        = '0;
        end else begin
          cnt_d[n]        = cnt_q[n] + 1'b1;
        end
      end else begin
        cnt_d[n] = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q       <= 2'b00;
      cnt_q        <= '0;
      soft_reset_q <= 3'b000;
    end else begin
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign bus.write_enb    = write_enb;
  assign bus.fifo_full    = fifo_full;
  assign bus.vld_out_0    = vld[0];
  assign bus.vld_out_1    = vld[1];
  assign bus.vld_out_2    = vld[2];
  assign bus.soft_reset_0 = soft_reset_q[0];
  assign bus.soft_reset_1 = soft_reset_q[1];
  assign bus.soft_reset_2 = soft_reset_q[2];
endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: address steering, full reporting, valid flags
// and the 30-cycle stall timeout including read and reset interruptions.
module tb_router_sync;
  logic clock;
  logic resetn;
  int   tests_run;
  int   tests_failed;

  router_sync_if bus ();

  router_sync #(.TIMEOUT_CYCLES(30), .CNT_W(5)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] soft_vec();
    return {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
  endfunction

  function automatic logic [2:0] vld_vec();
    return {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0};
  endfunction

  task automatic load_addr(input logic [1:0] a);
    bus.data_in    = a;
    bus.detect_add = 1'b1;
    tick();
    bus.detect_add = 1'b0;
    bus.data_in    = 2'b00;
    #1;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    resetn        = 1'b0;
    bus.data_in   = 2'b00;
    bus.detect_add = 1'b0;
    bus.full_0 = 1'b0; bus.full_1 = 1'b0; bus.full_2 = 1'b0;
    bus.empty_0 = 1'b1; bus.empty_1 = 1'b1; bus.empty_2 = 1'b1;
    bus.write_enb_reg = 1'b0;
    bus.read_enb_0 = 1'b0; bus.read_enb_1 = 1'b0; bus.read_enb_2 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    #1;

    // Reset state
    check("rst_write_enb", 32'(bus.write_enb), 32'h0);
    check("rst_fifo_full", 32'(bus.fifo_full), 32'h0);
    check("rst_vld_out",   32'(vld_vec()),     32'h0);
    check("rst_soft_reset", 32'(soft_vec()),   32'h0);

    // Address 01 steering and full selection
    bus.write_enb_reg = 1'b1;
    load_addr(2'b01);
    check("a01_write_enb", 32'(bus.write_enb), 32'h2);
    bus.full_1 = 1'b1; #1;
    check("a01_full1_set", 32'(bus.fifo_full), 32'h1);
    bus.full_1 = 1'b0; bus.full_0 = 1'b1; bus.full_2 = 1'b1; #1;
    check("a01_others_ignored", 32'(bus.fifo_full), 32'h0);
    bus.full_0 = 1'b0; bus.full_2 = 1'b0;

    // Address 00
    load_addr(2'b00);
    check("a00_write_enb", 32'(bus.write_enb), 32'h1);
    bus.full_0 = 1'b1; #1;
    check("a00_full0_set", 32'(bus.fifo_full), 32'h1);
    bus.full_0 = 1'b0; bus.full_1 = 1'b1; bus.full_2 = 1'b1; #1;
    check("a00_others_ignored", 32'(bus.fifo_full), 32'h0);
    bus.full_1 = 1'b0; bus.full_2 = 1'b0;

    // Address 10, fifo_full independent of write_enb_reg
    load_addr(2'b10);
    check("a10_write_enb", 32'(bus.write_enb), 32'h4);
    bus.full_2 = 1'b1; bus.write_enb_reg = 1'b0; #1;
    check("a10_full2_no_wr", 32'(bus.fifo_full), 32'h1);
    check("a10_no_wr_write_enb", 32'(bus.write_enb), 32'h0);
    bus.full_2 = 1'b0; bus.full_0 = 1'b1; bus.full_1 = 1'b1; bus.write_enb_reg = 1'b1; #1;
    check("a10_others_ignored", 32'(bus.fifo_full), 32'h0);

    // Invalid address 11
    bus.full_2 = 1'b1;
    load_addr(2'b11);
    check("a11_write_enb", 32'(bus.write_enb), 32'h0);
    check("a11_fifo_full", 32'(bus.fifo_full), 32'h0);
    bus.full_0 = 1'b0; bus.full_1 = 1'b0; bus.full_2 = 1'b0;

    // Address holds without detect_add; header with strobe uses old address until the edge
    load_addr(2'b01);
    tick(); tick();
    check("hold_write_enb", 32'(bus.write_enb), 32'h2);
    bus.data_in = 2'b10; bus.detect_add = 1'b1; #1;
    check("same_cycle_old_addr", 32'(bus.write_enb), 32'h2);
    tick();
    bus.detect_add = 1'b0; #1;
    check("same_cycle_new_addr", 32'(bus.write_enb), 32'h4);
    bus.write_enb_reg = 1'b0;

    // Port 1 valid and unread: pulses on edges 30 and 60 only
    bus.empty_1 = 1'b0; #1;
    check("p1_vld_out", 32'(vld_vec()), 32'h2);
    for (int k = 1; k <= 61; k++) begin
      tick();
      check($sformatf("p1_stall_k%0d", k), 32'(soft_vec()), (k % 30 == 0) ? 32'h2 : 32'h0);
    end

    // Clear, then read at the 20th cycle of a count: no pulse, count restarts
    bus.empty_1 = 1'b1; tick();
    bus.empty_1 = 1'b0;
    bus.read_enb_0 = 1'b1; bus.read_enb_2 = 1'b1;
    for (int k = 1; k <= 19; k++) tick();
    bus.read_enb_1 = 1'b1;
    tick();
    bus.read_enb_1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("p1_after_read_k%0d", k), 32'(soft_vec()), (k == 30) ? 32'h2 : 32'h0);
    end
    check("rd_empty_ports_vld", 32'(vld_vec()), 32'h2);
    bus.read_enb_0 = 1'b0; bus.read_enb_2 = 1'b0;

    // Reset at count 25 clears the timer; vld_out is unaffected by reset
    for (int k = 1; k <= 25; k++) tick();
    bus.write_enb_reg = 1'b1;
    resetn = 1'b0; #1;
    check("rst_mid_soft", 32'(soft_vec()), 32'h0);
    check("rst_mid_vld", 32'(vld_vec()), 32'h2);
    check("rst_mid_addr", 32'(bus.write_enb), 32'h1);
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("p1_after_rst_k%0d", k), 32'(soft_vec()), (k == 30) ? 32'h2 : 32'h0);
    end
    bus.write_enb_reg = 1'b0;

    // Ports 0 and 2 stall together: both pulse in the same cycle
    bus.empty_1 = 1'b1; tick();
    bus.empty_0 = 1'b0; bus.empty_2 = 1'b0; #1;
    check("p02_vld_out", 32'(vld_vec()), 32'h5);
    for (int k = 1; k <= 31; k++) begin
      tick();
      check($sformatf("p02_stall_k%0d", k), 32'(soft_vec()), (k == 30) ? 32'h5 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
